ps2_command_sender: RTL and testbench

Host-to-device PS/2 transmitter: takes a command byte (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset) and drives the PS/2 clock/data lines through the host-to-device sequence. The sequence is inhibit, start bit, 8 data bits LSB first, odd parity, stop, then device ACK. It sits beside `PS2_Controller` on the shared `PS2_CLK`/`PS2_DAT` inouts; the top level turns the two open-drain enables into tristate drives.

---
 rtl/ps2_command_sender_pkg.sv | 29 ++
 rtl/ps2_command_sender_line_sync.sv | 45 ++++
 rtl/ps2_command_sender.sv | 167 ++++++++++++++++
 tb/tb_ps2_command_sender.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_command_sender_pkg.sv
// Shared PS/2 definitions for the host-side blocks.
//   ps2_tx_state_t  : transmitter FSM states (IDLE..RELEASE, 3 bits)
//   PS2_*_DEFAULT   : default timing constants for a 50 MHz clock
//   PS2_CMD_*       : common host command bytes and the device ACK byte
//   ps2_odd_parity  : parity bit that makes data+parity hold an odd count of ones
package ps2_command_sender_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INHIBIT = 3'd1,
    ST_START   = 3'd2,
    ST_TX      = 3'd3,
    ST_ACK     = 3'd4,
    ST_RELEASE = 3'd5
  } ps2_tx_state_t;

  localparam int PS2_CLK_INHIBIT_DEFAULT  = 5500;    // 110 us at 50 MHz
  localparam int PS2_DEVICE_TIMEOUT_DEFAULT = 100000; // 2 ms at 50 MHz

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_command_sender_line_sync.sv
// ps2_line_sync: brings the raw PS/2 clock and data pins into the CLOCK_50
// domain and flags falling edges of the device clock.
//   CLOCK_50   in  : system clock, rising edge
//   reset_n    in  : synchronous active-low reset
//   ps2_clk_in in  : raw PS2_CLK pin level (asynchronous)
//   ps2_dat_in in  : raw PS2_DAT pin level (asynchronous)
//   clk_sync   out : synchronized clock line level
//   dat_sync   out : synchronized data line level
//   clk_fall   out : registered one-cycle pulse, 3 cycles after a pin falling edge
module ps2_line_sync
  import ps2_command_sender_pkg::*;
(
  input  logic CLOCK_50,
  input  logic reset_n,
  input  logic ps2_clk_in,
  input  logic ps2_dat_in,
  output logic clk_sync,
  output logic dat_sync,
  output logic clk_fall
);

  logic [1:0] clk_meta;
  logic [1:0] dat_meta;
  logic       clk_prev;

  // Reset to the idle (released, high) level so leaving reset never looks
  // like a falling edge.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      clk_meta <= '1;
      dat_meta <= '1;
      clk_prev <= 1'b1;
      clk_fall <= 1'b0;
    end else begin
      clk_meta <= {clk_meta[0], ps2_clk_in};
      dat_meta <= {dat_meta[0], ps2_dat_in};
      clk_prev <= clk_meta[1];
      clk_fall <= clk_prev & ~clk_meta[1];
    end
  end

  assign clk_sync = clk_meta[1];
  assign dat_sync = dat_meta[1];

endmodule

// File: rtl/ps2_command_sender.sv
// ps2_command_sender: host-to-device PS/2 transmitter. Inhibits the bus,
// issues the start bit, shifts out 8 data bits LSB first, odd parity and
// stop on device clock falling edges, then checks the device ACK.
//   CLOCK_50      in  : system clock, rising edge
//   reset_n       in  : synchronous active-low reset
//   send_command  in  : byte to send, sampled when send_en is accepted
//   send_en       in  : single-cycle request, accepted only in IDLE
//   ps2_clk_in    in  : raw PS2_CLK pin level
//   ps2_dat_in    in  : raw PS2_DAT pin level
//   ps2_clk_oe    out : 1 pulls PS2_CLK low
//   ps2_dat_oe    out : 1 pulls PS2_DAT low
//   busy          out : high from acceptance until return to IDLE
//   command_sent  out : pulse, ACK received and lines released
//   error_nack    out : pulse, ACK bit sampled high
//   error_timeout out : pulse, device stalled too long
module ps2_command_sender
  import ps2_command_sender_pkg::*;
#(
  parameter int CLK_INHIBIT_CYCLES = PS2_CLK_INHIBIT_DEFAULT,
  parameter int DEVICE_TIMEOUT     = PS2_DEVICE_TIMEOUT_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [7:0] send_command,
  input  logic       send_en,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       command_sent,
  output logic       error_nack,
  output logic       error_timeout
);

  localparam logic [31:0] INHIBIT_LAST = 32'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(DEVICE_TIMEOUT - 1);

  ps2_tx_state_t state;
  logic [9:0]    shift;
  logic [3:0]    idx;
  logic [31:0]   cnt;
  logic          clk_sync;
  logic          dat_sync;
  logic          clk_fall;
  logic          timed_out;

  ps2_line_sync u_sync (
    .CLOCK_50   (CLOCK_50),
    .reset_n    (reset_n),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .clk_sync   (clk_sync),
    .dat_sync   (dat_sync),
    .clk_fall   (clk_fall)
  );

  // The counter restarts on TX entry and on every device clock fall, so a
  // match here means DEVICE_TIMEOUT cycles have passed with no progress.
  assign timed_out = (cnt == TIMEOUT_LAST);

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      shift         <= '0;
      idx           <= '0;
      cnt           <= '0;
      ps2_clk_oe    <= 1'b0;
      ps2_dat_oe    <= 1'b0;
      busy          <= 1'b0;
      command_sent  <= 1'b0;
      error_nack    <= 1'b0;
      error_timeout <= 1'b0;
    end else begin
      command_sent  <= 1'b0;
      error_nack    <= 1'b0;
      error_timeout <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (send_en) begin
            shift      <= {1'b1, ps2_odd_parity(send_command), send_command};
            cnt        <= '0;
            busy       <= 1'b1;
            ps2_clk_oe <= 1'b1;
            state      <= ST_INHIBIT;
          end
        end
        ST_INHIBIT: begin
          // Start bit goes out on the same edge that leaves INHIBIT so that
          // START holds both lines low for exactly one cycle.
          if (cnt == INHIBIT_LAST) begin
            ps2_dat_oe <= 1'b1;
            state      <= ST_START;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_START: begin
          ps2_clk_oe <= 1'b0;
          cnt        <= '0;
          idx        <= '0;
          state      <= ST_TX;
        end
        ST_TX: begin
          if (clk_fall) begin
            cnt        <= '0;
            ps2_dat_oe <= ~shift[idx];
            idx        <= idx + 4'd1;
            if (idx == 4'd9) state <= ST_ACK;
          end else if (timed_out) begin
            error_timeout <= 1'b1;
            ps2_clk_oe    <= 1'b0;
            ps2_dat_oe    <= 1'b0;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_ACK: begin
          if (clk_fall) begin
            cnt <= '0;
            if (!dat_sync) begin
              state <= ST_RELEASE;
            end else begin
              error_nack <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_IDLE;
            end
          end else if (timed_out) begin
            error_timeout <= 1'b1;
            ps2_clk_oe    <= 1'b0;
            ps2_dat_oe    <= 1'b0;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_RELEASE: begin
          if (clk_sync && dat_sync) begin
            command_sent <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end else if (timed_out) begin
            error_timeout <= 1'b1;
            ps2_clk_oe    <= 1'b0;
            ps2_dat_oe    <= 1'b0;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_command_sender.sv
module tb_ps2_command_sender;

  localparam int CIC = 20;
  localparam int DT  = 200;
  localparam int H   = 30;   // device clock half period in system cycles

  logic       CLOCK_50 = 1'b0;
  logic       reset_n;
  logic [7:0] send_command;
  logic       send_en;
  logic       ps2_clk_oe, ps2_dat_oe, busy;
  logic       command_sent, error_nack, error_timeout;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       ps2_clk_in, ps2_dat_in;

  // Open-drain bus: either side pulling low wins.
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_command_sender #(
    .CLK_INHIBIT_CYCLES (CIC),
    .DEVICE_TIMEOUT     (DT)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset_n       (reset_n),
    .send_command  (send_command),
    .send_en       (send_en),
    .ps2_clk_in    (ps2_clk_in),
    .ps2_dat_in    (ps2_dat_in),
    .ps2_clk_oe    (ps2_clk_oe),
    .ps2_dat_oe    (ps2_dat_oe),
    .busy          (busy),
    .command_sent  (command_sent),
    .error_nack    (error_nack),
    .error_timeout (error_timeout)
  );

  int errors = 0;
  int checks = 0;
  int n_sent = 0, n_nack = 0, n_to = 0;

  always @(negedge CLOCK_50) begin
    if (command_sent)  n_sent++;
    if (error_nack)    n_nack++;
    if (error_timeout) n_to++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_send(input logic [7:0] cmd);
    @(negedge CLOCK_50);
    send_command = cmd;
    send_en      = 1'b1;
    @(negedge CLOCK_50);
    send_en      = 1'b0;
  endtask

  // Device side: waits for the start bit, generates nfalls clock pulses and
  // samples the host data bit at the end of each low phase. On the 11th
  // pulse it pulls DAT low as the ACK when ack=1.
  task automatic device_receive(input int nfalls, input bit ack,
                                output logic [9:0] got, output bit ok);
    ok  = 1'b0;
    got = '0;
    for (int w = 0; w < 1000; w++) begin
      @(negedge CLOCK_50);
      if (!ps2_clk_oe && ps2_dat_oe) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      for (int i = 0; i < nfalls; i++) begin
        if (i == 10 && ack) dev_dat_low = 1'b1;
        repeat (H) @(negedge CLOCK_50);
        dev_clk_low = 1'b1;
        repeat (H) @(negedge CLOCK_50);
        if (i < 10) got[i] = ps2_dat_in;
        dev_clk_low = 1'b0;
      end
      repeat (2) @(negedge CLOCK_50);
      dev_dat_low = 1'b0;
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int w = 0; w < 400; w++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLOCK_50);
    end
    repeat (2) @(negedge CLOCK_50);
  endtask

  typedef struct {
    logic [7:0] cmd;
    bit         ack;
    logic       par;    // hand-computed odd parity
    int         sent;
    int         nack;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input vec_t v);
    logic [9:0] got;
    bit         ok, idle_ok;
    n_sent = 0; n_nack = 0; n_to = 0;
    pulse_send(v.cmd);
    device_receive(11, v.ack, got, ok);
    wait_idle(idle_ok);
    check($sformatf("start_seen_%02h", v.cmd), 32'(ok), 32'd1);
    check($sformatf("frame_%02h", v.cmd), 32'(got), 32'({1'b1, v.par, v.cmd}));
    check($sformatf("sent_%02h", v.cmd), 32'(n_sent), 32'(v.sent));
    check($sformatf("nack_%02h", v.cmd), 32'(n_nack), 32'(v.nack));
    check($sformatf("timeout_%02h", v.cmd), 32'(n_to), 32'd0);
    check($sformatf("idle_%02h", v.cmd), 32'(idle_ok), 32'd1);
    check($sformatf("oe_after_%02h", v.cmd), 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] got;
    bit         ok, idle_ok;
    int         t_dat, t_clk, t_to;

    vecs[0] = '{cmd: 8'hED, ack: 1'b1, par: 1'b1, sent: 1, nack: 0};
    vecs[1] = '{cmd: 8'hF4, ack: 1'b1, par: 1'b0, sent: 1, nack: 0};
    vecs[2] = '{cmd: 8'hFF, ack: 1'b0, par: 1'b1, sent: 0, nack: 1};
    vecs[3] = '{cmd: 8'h00, ack: 1'b1, par: 1'b1, sent: 1, nack: 0};
    vecs[4] = '{cmd: 8'h01, ack: 1'b1, par: 1'b0, sent: 1, nack: 0};

    reset_n      = 1'b0;
    send_en      = 1'b0;
    send_command = 8'h00;
    repeat (3) @(negedge CLOCK_50);
    check("reset_outputs",
          32'({ps2_clk_oe, ps2_dat_oe, busy, command_sent, error_nack, error_timeout}), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Start timing and timeout: no device activity at all.
    n_to = 0;
    pulse_send(8'hF4);
    check("accept_busy", 32'(busy), 32'd1);
    check("accept_clk_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'b10);
    t_dat = -1; t_clk = -1; t_to = -1;
    for (int t = 0; t < 1000; t++) begin
      if (ps2_dat_oe && t_dat < 0) t_dat = t;
      if (t_dat >= 0 && !ps2_clk_oe && t_clk < 0) t_clk = t;
      if (error_timeout) begin
        t_to = t;
        check("timeout_lines", 32'({ps2_clk_oe, ps2_dat_oe, busy}), 32'd0);
        break;
      end
      @(negedge CLOCK_50);
    end
    check("start_bit_time", 32'(t_dat), 32'(CIC));
    check("clk_release_time", 32'(t_clk), 32'(CIC + 1));
    check("timeout_time", 32'(t_to), 32'(CIC + 1 + DT));
    repeat (3) @(negedge CLOCK_50);
    check("timeout_pulses", 32'(n_to), 32'd1);

    // Reset while bit 4 is on the line.
    pulse_send(8'hED);
    device_receive(5, 1'b0, got, ok);
    check("mid_busy", 32'({ok, busy}), 32'b11);
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    check("reset_release", 32'({ps2_clk_oe, ps2_dat_oe, busy}), 32'd0);
    reset_n = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    run_vec(vecs[0]);

    // A second request mid-transfer must be dropped.
    n_sent = 0; n_nack = 0; n_to = 0;
    pulse_send(8'hF4);
    fork
      device_receive(11, 1'b1, got, ok);
      begin
        repeat (200) @(negedge CLOCK_50);
        send_command = 8'h00;
        send_en      = 1'b1;
        @(negedge CLOCK_50);
        send_en      = 1'b0;
      end
    join
    wait_idle(idle_ok);
    check("ignore_frame", 32'(got), 32'({1'b1, 1'b0, 8'hF4}));
    check("ignore_sent", 32'(n_sent), 32'd1);
    repeat (5) @(negedge CLOCK_50);
    check("ignore_not_queued", 32'({busy, ps2_clk_oe}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
